musb_memory_access: RTL and testbench
=====================================

Name: musb_memory_access

Overview:
- MEM-stage data-port initiator. It consumes the EX→MEM pipeline register outputs (address, store data, access size/type, LL/SC, kernel mode) and runs a ready/error handshake on the data bus.
- It returns aligned, extended load data and an SC success/fail result, and raises address, protection and bus exceptions.
- It requests a pipeline stall while a bus access is outstanding.

Parameters:
- USER_LIMIT, 32'h8000_0000, first address illegal in user mode.
- TIMEOUT, 255, cycles waited for dport_ready/dport_error before a bus error is forced (8-bit counter).

Ports:
- clk  in  1  main clock
- rst  in  1  reset, asynchronous, active-low (asserted when 0)
- mem_address  in  32  ALU result, effective address
- mem_store_data  in  32  unaligned store data (low bits)
- mem_read  in  1  load op (mem_to_gpr_select)
- mem_write  in  1  store op
- mem_byte  in  1  byte access
- mem_halfword  in  1  halfword access
- mem_sign_ext  in  1  sign-extend load data
- mem_llsc  in  1  LL when read, SC when write
- mem_kernel_mode  in  1  privileged access
- mem_flush  in  1  kill op in MEM
- llsc_clear  in  1  ERET or exception; clears link
- dport_address  out  32  word address ({addr[31:2],2'b00})
- dport_data_o  out  32  lane-replicated store data
- dport_be  out  4  byte enables, big-endian (4'b1000 = bits 31:24)
- dport_we  out  1  write strobe
- dport_enable  out  1  request valid
- dport_data_i  in  32  read data
- dport_ready  in  1  access complete
- dport_error  in  1  bus error
- mem_read_data  out  32  extended load data / SC result (1 or 0)
- mem_sc_fail  out  1  SC failed; no store issued
- mem_stall_req  out  1  stall MEM and earlier stages
- exc_address_load  out  1  misaligned/protected load
- exc_address_store  out  1  misaligned/protected store
- exc_bus_error  out  1  bus error or timeout, one-cycle pulse

Behaviour:
- Reset (rst=0, async): state=IDLE. All outputs 0. llsc_valid=0, llsc_addr=0, timeout counter=0. Reset mid-WAIT drops dport_enable immediately.
- Access valid: (mem_read|mem_write) & ~mem_flush.
- Misaligned access: halfword with addr[0]=1, or word with addr[1:0]≠0.
- Protected access: ~mem_kernel_mode & addr ≥ USER_LIMIT.
- Exceptions are combinational in IDLE: load raises exc_address_load; store raises exc_address_store. No bus request is issued and no stall is raised.
- Byte enables:
  - byte: 4'b1000 >> addr[1:0]
  - halfword: addr[1] ? 4'b0011 : 4'b1100
  - word: 4'b1111
- Store data: byte {4{d[7:0]}}, halfword {2{d[15:0]}}, word d.
- Load extraction: select the lane matching the enables, then zero- or sign-extend to 32 bits per mem_sign_ext.
- SC fails when ~llsc_valid or llsc_addr ≠ addr[31:2]. On fail: no bus access, mem_sc_fail=1, mem_read_data=0, no stall. The instruction completes in that cycle.
- FSM IDLE:
  - Access valid with no exception and no SC fail: mem_stall_req=1 (combinational). Register address, be, data and we; set dport_enable=1; go to WAIT.
- FSM WAIT:
  - mem_stall_req=1 and the counter increments.
  - dport_ready: register mem_read_data. For SC, mem_read_data=1. Drop dport_enable and go to DONE.
  - dport_error or counter==TIMEOUT: pulse exc_bus_error, drop dport_enable, go to DONE.
  - dport_ready and dport_error in the same cycle: error wins.
- FSM DONE: mem_stall_req=0 for exactly one cycle so the pipeline advances; then go to IDLE.
- Minimum access is 3 cycles: IDLE, WAIT(1), DONE.
- mem_flush during WAIT: the bus access is not aborted and stall holds until ready or error. The result is discarded, no bus-error pulse is raised, and the FSM goes WAIT→IDLE.
- LL completion sets llsc_valid=1 and llsc_addr=addr[31:2].
- llsc_valid is cleared by:
  - successful SC
  - any completed store to llsc_addr
  - llsc_clear (highest priority over a same-cycle LL set)
- mem_read_data holds its value until the next completed load or SC.

Decomposition:
- musb_pkg (shared package) holds:
  - FSM state encodings (IDLE, WAIT, DONE)
  - the byte-enable constants
  - the USER_LIMIT default
- One sub-module, musb_load_align: combinational lane select and extend from (data, addr[1:0], byte, halfword, sign_ext). It is reused by the instruction port.
- The byte-enable and store-replicate logic stays inline.

Test Plan:
- LB, addr 0x0000_0101, sign_ext=1, dport_data_i=0x12F4_5678, ready after 2 cycles → dport_be=4'b0100, mem_read_data=0xFFFF_FFF4, stall high for 3 cycles then low for 1.
- SH, addr 0x0000_0202, data 0x0000_ABCD → dport_be=4'b0011, dport_data_o=0xABCD_ABCD, dport_we=1.
- LW, addr 0x0000_0006 → exc_address_load=1, dport_enable never asserts, no stall. User-mode SW to 0x8000_0000 → exc_address_store=1.
- LL 0x100 then SC 0x100 → store issued, mem_read_data=1. A second SC 0x100 → no bus access, mem_sc_fail=1, mem_read_data=0. LL then llsc_clear then SC → fails.
- dport_ready never asserted → exc_bus_error pulses after TIMEOUT cycles, dport_enable drops, DONE, IDLE.
- rst=0 asserted during WAIT → dport_enable=0 and stall=0 without a clock edge. A flush during WAIT, then ready → no write-back, no bus-error pulse, IDLE.

Source files
------------

// File: rtl/musb_pkg.sv
// Shared definitions for the MUSB memory-access stage.
// - FSM state encodings (legacy localparam values, wrapped in an enum type)
// - big-endian byte-enable constants (4'b1000 selects bits 31:24)
// - default user-mode address limit and bus timeout
package musb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_WAIT = ST_WAIT,
    S_DONE = ST_DONE
  } state_t;

  localparam logic [3:0] BE_BYTE0   = 4'b1000;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  localparam logic [31:0] DEF_USER_LIMIT = 32'h8000_0000;
  localparam int unsigned DEF_TIMEOUT    = 255;

endpackage

// File: rtl/musb_load_align.sv
// Load lane select and extension (big-endian lanes).
// Ports:
//   i_data     : 32-bit word read from the bus
//   i_addr     : byte offset within the word
//   i_byte     : byte access
//   i_halfword : halfword access (word when neither is set)
//   i_sign_ext : sign-extend instead of zero-extend
//   o_data     : aligned, extended result
module musb_load_align (
  input  logic [31:0] i_data,
  input  logic [1:0]  i_addr,
  input  logic        i_byte,
  input  logic        i_halfword,
  input  logic        i_sign_ext,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = '0;
    case (i_addr)
      2'd0: w_byte = i_data[31:24];
      2'd1: w_byte = i_data[23:16];
      2'd2: w_byte = i_data[15:8];
      default: w_byte = i_data[7:0];
    endcase
    w_half = i_addr[1] ? i_data[15:0] : i_data[31:16];

    if (i_byte) begin
      o_data = {{24{i_sign_ext & w_byte[7]}}, w_byte};
    end else if (i_halfword) begin
      o_data = {{16{i_sign_ext & w_half[15]}}, w_half};
    end else begin
      o_data = i_data;
    end
  end

endmodule

// File: rtl/musb_memory_access.sv
// MEM-stage data-port initiator.
// Takes the EX->MEM register outputs, checks alignment/protection and LL/SC
// link state, runs one ready/error handshake on the data port and returns
// aligned load data or the SC result. Stalls the pipeline while the access
// is outstanding and releases it for exactly one cycle (DONE) on completion.
// Ports:
//   clk, rst (async, active-low)
//   mem_*            : pipeline-side request and result signals
//   llsc_clear       : drop the LL link (ERET/exception)
//   dport_*          : data bus request / response
//   exc_address_*    : combinational alignment/protection exceptions
//   exc_bus_error    : one-cycle pulse on bus error or timeout
module musb_memory_access
  import musb_pkg::*;
#(
  parameter logic [31:0] USER_LIMIT = DEF_USER_LIMIT,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_store_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        mem_byte,
  input  logic        mem_halfword,
  input  logic        mem_sign_ext,
  input  logic        mem_llsc,
  input  logic        mem_kernel_mode,
  input  logic        mem_flush,
  input  logic        llsc_clear,
  output logic [31:0] dport_address,
  output logic [31:0] dport_data_o,
  output logic [3:0]  dport_be,
  output logic        dport_we,
  output logic        dport_enable,
  input  logic [31:0] dport_data_i,
  input  logic        dport_ready,
  input  logic        dport_error,
  output logic [31:0] mem_read_data,
  output logic        mem_sc_fail,
  output logic        mem_stall_req,
  output logic        exc_address_load,
  output logic        exc_address_store,
  output logic        exc_bus_error
);

  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

  state_t      r_state;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic [3:0]  r_be;
  logic        r_we;
  logic        r_enable;
  logic        r_byte;
  logic        r_halfword;
  logic        r_sign_ext;
  logic        r_is_read;
  logic        r_is_ll;
  logic        r_is_sc;
  logic        r_flushed;
  logic [7:0]  r_count;
  logic [31:0] r_read_data;
  logic        r_bus_err;
  logic        r_llsc_valid;
  logic [29:0] r_llsc_addr;

  logic        w_valid;
  logic        w_misaligned;
  logic        w_protected;
  logic        w_exc;
  logic        w_sc_fail;
  logic        w_idle_op;
  logic        w_start;
  logic [3:0]  w_be;
  logic [31:0] w_store;
  logic [31:0] w_load;
  logic        w_flush_now;
  logic        w_fail;
  logic        w_complete;

  musb_load_align u_align (
    .i_data     (dport_data_i),
    .i_addr     (r_addr[1:0]),
    .i_byte     (r_byte),
    .i_halfword (r_halfword),
    .i_sign_ext (r_sign_ext),
    .o_data     (w_load)
  );

  always_comb begin
    w_valid      = (mem_read | mem_write) & ~mem_flush;
    w_misaligned = (mem_halfword & mem_address[0]) |
                   (~mem_byte & ~mem_halfword & (|mem_address[1:0]));
    w_protected  = ~mem_kernel_mode & (mem_address >= USER_LIMIT);
    w_exc        = w_misaligned | w_protected;
    w_sc_fail    = mem_write & mem_llsc &
                   (~r_llsc_valid | (r_llsc_addr != mem_address[31:2]));
    // Gated by rst so every output reads 0 while reset is held.
    w_idle_op    = rst & (r_state == S_IDLE) & w_valid;
    w_start      = w_idle_op & ~w_exc & ~w_sc_fail;

    if (mem_byte) begin
      w_be    = BE_BYTE0 >> mem_address[1:0];
      w_store = {4{mem_store_data[7:0]}};
    end else if (mem_halfword) begin
      w_be    = mem_address[1] ? BE_HALF_LO : BE_HALF_HI;
      w_store = {2{mem_store_data[15:0]}};
    end else begin
      w_be    = BE_WORD;
      w_store = mem_store_data;
    end

    w_flush_now = r_flushed | mem_flush;
    w_fail      = dport_error | (r_count == LP_TIMEOUT);
    w_complete  = (r_state == S_WAIT) & dport_ready & ~w_fail & ~w_flush_now;

    exc_address_load  = w_idle_op & w_exc & mem_read;
    exc_address_store = w_idle_op & w_exc & mem_write;
    mem_sc_fail       = w_idle_op & ~w_exc & w_sc_fail;
    mem_stall_req     = w_start | (rst & (r_state == S_WAIT));
    mem_read_data     = mem_sc_fail ? '0 : r_read_data;
  end

  assign dport_address = {r_addr[31:2], 2'b00};
  assign dport_data_o  = r_data;
  assign dport_be      = r_be;
  assign dport_we      = r_we;
  assign dport_enable  = r_enable;
  assign exc_bus_error = r_bus_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_data      <= '0;
      r_be        <= '0;
      r_we        <= 1'b0;
      r_enable    <= 1'b0;
      r_byte      <= 1'b0;
      r_halfword  <= 1'b0;
      r_sign_ext  <= 1'b0;
      r_is_read   <= 1'b0;
      r_is_ll     <= 1'b0;
      r_is_sc     <= 1'b0;
      r_flushed   <= 1'b0;
      r_count     <= '0;
      r_read_data <= '0;
      r_bus_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_bus_err <= 1'b0;
          if (mem_sc_fail) begin
            r_read_data <= '0;
          end
          if (w_start) begin
            r_addr     <= mem_address;
            r_data     <= w_store;
            r_be       <= w_be;
            r_we       <= mem_write;
            r_enable   <= 1'b1;
            r_byte     <= mem_byte;
            r_halfword <= mem_halfword;
            r_sign_ext <= mem_sign_ext;
            r_is_read  <= mem_read;
            r_is_ll    <= mem_read & mem_llsc;
            r_is_sc    <= mem_write & mem_llsc;
            r_flushed  <= 1'b0;
            r_count    <= '0;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_count   <= r_count + 8'd1;
          r_flushed <= w_flush_now;
          // A flushed access still runs to completion on the bus, but its
          // result and any error are dropped and DONE is skipped.
          if (w_fail) begin
            r_enable  <= 1'b0;
            r_we      <= 1'b0;
            r_bus_err <= ~w_flush_now;
            r_state   <= w_flush_now ? S_IDLE : S_DONE;
          end else if (dport_ready) begin
            r_enable <= 1'b0;
            r_we     <= 1'b0;
            if (!w_flush_now && (r_is_read || r_is_sc)) begin
              r_read_data <= r_is_sc ? 32'd1 : w_load;
            end
            r_state <= w_flush_now ? S_IDLE : S_DONE;
          end
        end
        S_DONE: begin
          r_bus_err <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_llsc_valid <= 1'b0;
      r_llsc_addr  <= '0;
    end else if (llsc_clear) begin
      r_llsc_valid <= 1'b0;
    end else if (w_complete) begin
      if (r_is_ll) begin
        r_llsc_valid <= 1'b1;
        r_llsc_addr  <= r_addr[31:2];
      end else if (r_we && (r_is_sc || (r_addr[31:2] == r_llsc_addr))) begin
        r_llsc_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_musb_memory_access.sv
module tb_musb_memory_access;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] mem_address = '0;
  logic [31:0] mem_store_data = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic        mem_byte = 1'b0;
  logic        mem_halfword = 1'b0;
  logic        mem_sign_ext = 1'b0;
  logic        mem_llsc = 1'b0;
  logic        mem_kernel_mode = 1'b1;
  logic        mem_flush = 1'b0;
  logic        llsc_clear = 1'b0;
  logic [31:0] dport_address;
  logic [31:0] dport_data_o;
  logic [3:0]  dport_be;
  logic        dport_we;
  logic        dport_enable;
  logic [31:0] dport_data_i = '0;
  logic        dport_ready = 1'b0;
  logic        dport_error = 1'b0;
  logic [31:0] mem_read_data;
  logic        mem_sc_fail;
  logic        mem_stall_req;
  logic        exc_address_load;
  logic        exc_address_store;
  logic        exc_bus_error;

  musb_memory_access #(.USER_LIMIT(32'h8000_0000), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .mem_address(mem_address), .mem_store_data(mem_store_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte(mem_byte),
    .mem_halfword(mem_halfword), .mem_sign_ext(mem_sign_ext),
    .mem_llsc(mem_llsc), .mem_kernel_mode(mem_kernel_mode),
    .mem_flush(mem_flush), .llsc_clear(llsc_clear),
    .dport_address(dport_address), .dport_data_o(dport_data_o),
    .dport_be(dport_be), .dport_we(dport_we), .dport_enable(dport_enable),
    .dport_data_i(dport_data_i), .dport_ready(dport_ready),
    .dport_error(dport_error), .mem_read_data(mem_read_data),
    .mem_sc_fail(mem_sc_fail), .mem_stall_req(mem_stall_req),
    .exc_address_load(exc_address_load), .exc_address_store(exc_address_store),
    .exc_bus_error(exc_bus_error)
  );

  always #5 clk = ~clk;

  localparam int K_REQ  = 0;
  localparam int K_DONE = 1;
  localparam int K_IMM  = 2;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
    logic        we;
    logic [31:0] rd;
    logic        berr;
    int          stall;
    logic        el;
    logic        es;
    logic        scf;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t blank(input int kind);
    exp_t e;
    e.kind = kind; e.addr = '0; e.be = '0; e.data = '0; e.we = 1'b0;
    e.rd = '0; e.berr = 1'b0; e.stall = 0; e.el = 1'b0; e.es = 1'b0; e.scf = 1'b0;
    return e;
  endfunction

  task automatic push_req(input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] d, input logic we);
    exp_t e = blank(K_REQ);
    e.addr = a; e.be = be; e.data = d; e.we = we;
    q.push_back(e);
  endtask

  task automatic push_done(input logic [31:0] rd, input logic berr, input int stall);
    exp_t e = blank(K_DONE);
    e.rd = rd; e.berr = berr; e.stall = stall;
    q.push_back(e);
  endtask

  task automatic push_imm(input logic el, input logic es, input logic scf);
    exp_t e = blank(K_IMM);
    e.el = el; e.es = es; e.scf = scf;
    q.push_back(e);
  endtask

  // Monitor: pops an expectation whenever the DUT presents an event.
  initial begin : monitor
    logic prev_en;
    logic prev_stall;
    int   stall_cnt;
    logic fell;
    exp_t e;
    prev_en = 1'b0; prev_stall = 1'b0; stall_cnt = 0;
    forever begin
      @(negedge clk);
      fell = rst && prev_stall && !mem_stall_req;
      if (rst) begin
        if (dport_enable && !prev_en) begin
          chk("req_expected", 32'(q.size() > 0 && q[0].kind == K_REQ), 32'd1);
          if (q.size() > 0 && q[0].kind == K_REQ) begin
            e = q.pop_front();
            chk("req_addr", dport_address, e.addr);
            chk("req_be", 32'(dport_be), 32'(e.be));
            chk("req_data", dport_data_o, e.data);
            chk("req_we", 32'(dport_we), 32'(e.we));
          end
        end
        if (fell) begin
          chk("done_expected", 32'(q.size() > 0 && q[0].kind == K_DONE), 32'd1);
          if (q.size() > 0 && q[0].kind == K_DONE) begin
            e = q.pop_front();
            chk("done_read_data", mem_read_data, e.rd);
            chk("done_bus_error", 32'(exc_bus_error), 32'(e.berr));
            chk("done_enable_low", 32'(dport_enable), 32'd0);
            chk("done_stall_cycles", 32'(stall_cnt), 32'(e.stall));
          end
        end
        if (exc_address_load || exc_address_store || mem_sc_fail) begin
          chk("imm_expected", 32'(q.size() > 0 && q[0].kind == K_IMM), 32'd1);
          if (q.size() > 0 && q[0].kind == K_IMM) begin
            e = q.pop_front();
            chk("imm_flags", {29'd0, exc_address_load, exc_address_store, mem_sc_fail},
                {29'd0, e.el, e.es, e.scf});
            chk("imm_no_stall", 32'(mem_stall_req), 32'd0);
            chk("imm_no_enable", 32'(dport_enable), 32'd0);
            if (e.scf) chk("imm_sc_read_data", mem_read_data, 32'd0);
          end
        end
        if (exc_bus_error && !fell) begin
          failures++;
          $display("FAIL stray_bus_error actual=1 expected=0 t=%0t", $time);
        end
      end
      stall_cnt  = (rst && mem_stall_req) ? stall_cnt + 1 : 0;
      prev_en    = rst ? dport_enable : 1'b0;
      prev_stall = rst ? mem_stall_req : 1'b0;
    end
  end

  task automatic drive(input logic rd, input logic wr, input logic bt, input logic hw,
                       input logic sx, input logic ll, input logic km,
                       input logic [31:0] a, input logic [31:0] sd, input logic [31:0] di);
    mem_read = rd; mem_write = wr; mem_byte = bt; mem_halfword = hw;
    mem_sign_ext = sx; mem_llsc = ll; mem_kernel_mode = km;
    mem_address = a; mem_store_data = sd; dport_data_i = di;
  endtask

  task automatic idle_inputs();
    mem_read = 1'b0; mem_write = 1'b0; mem_flush = 1'b0; mem_llsc = 1'b0;
    mem_byte = 1'b0; mem_halfword = 1'b0; mem_sign_ext = 1'b0;
    mem_kernel_mode = 1'b1; dport_ready = 1'b0; dport_error = 1'b0;
  endtask

  // Bus op: responds with ready at WAIT cycle rdy, error at err_at,
  // flush at flush_at (0 = never); returns once stall drops.
  task automatic bus_op(input logic rd, input logic wr, input logic bt, input logic hw,
                        input logic sx, input logic ll, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] di,
                        input int rdy, input int err_at, input int flush_at);
    int  n;
    bit  done;
    @(posedge clk); #1;
    drive(rd, wr, bt, hw, sx, ll, 1'b1, a, sd, di);
    n = 0; done = 0;
    while (!done && n < 400) begin
      @(posedge clk); #1;
      dport_ready = 1'b0; dport_error = 1'b0;
      n++;
      if (!mem_stall_req) done = 1;
      else begin
        if (n == rdy) dport_ready = 1'b1;
        if (n == err_at) dport_error = 1'b1;
        if (n == flush_at) mem_flush = 1'b1;
      end
    end
    if (!done) begin
      failures++;
      $display("FAIL bus_op_bound actual=stall_held expected=release t=%0t", $time);
    end
    idle_inputs();
  endtask

  task automatic imm_op(input logic rd, input logic wr, input logic hw, input logic ll,
                        input logic km, input logic [31:0] a);
    @(posedge clk); #1;
    drive(rd, wr, 1'b0, hw, 1'b0, ll, km, a, 32'h0, 32'h0);
    @(posedge clk); #1;
    idle_inputs();
  endtask

  initial begin : watchdog
    #500000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : stim
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_enable", 32'(dport_enable), 32'd0);
    chk("rst_stall", 32'(mem_stall_req), 32'd0);
    chk("rst_read_data", mem_read_data, 32'd0);
    chk("rst_address", dport_address, 32'd0);
    chk("rst_bus_error", 32'(exc_bus_error), 32'd0);
    rst = 1'b1;

    // LB sign-extended, lane 1
    push_req(32'h0000_0100, 4'b0100, 32'h0, 1'b0);
    push_done(32'hFFFF_FFF4, 1'b0, 3);
    bus_op(1, 0, 1, 0, 1, 0, 32'h0000_0101, 32'h0, 32'h12F4_5678, 2, 0, 0);

    // SH lower half, replicated
    push_req(32'h0000_0200, 4'b0011, 32'hABCD_ABCD, 1'b1);
    push_done(32'hFFFF_FFF4, 1'b0, 2);
    bus_op(0, 1, 0, 1, 0, 0, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 1, 0, 0);

    // LHU upper half, zero-extended
    push_req(32'h0000_0200, 4'b1100, 32'h0, 1'b0);
    push_done(32'h0000_8001, 1'b0, 2);
    bus_op(1, 0, 0, 1, 0, 0, 32'h0000_0200, 32'h0, 32'h8001_7FFF, 1, 0, 0);

    // Misaligned LW, protected user SW
    push_imm(1'b1, 1'b0, 1'b0);
    imm_op(1, 0, 0, 0, 1, 32'h0000_0006);
    push_imm(1'b0, 1'b1, 1'b0);
    imm_op(0, 1, 0, 0, 0, 32'h8000_0000);

    // LL / SC success / SC fail
    push_req(32'h0000_0100, 4'b1111, 32'h0, 1'b0);
    push_done(32'hCAFE_BABE, 1'b0, 2);
    bus_op(1, 0, 0, 0, 0, 1, 32'h0000_0100, 32'h0, 32'hCAFE_BABE, 1, 0, 0);
    push_req(32'h0000_0100, 4'b1111, 32'h1122_3344, 1'b1);
    push_done(32'h0000_0001, 1'b0, 2);
    bus_op(0, 1, 0, 0, 0, 1, 32'h0000_0100, 32'h1122_3344, 32'h0, 1, 0, 0);
    push_imm(1'b0, 1'b0, 1'b1);
    imm_op(0, 1, 0, 1, 1, 32'h0000_0100);

    // LL, llsc_clear, SC fails
    push_req(32'h0000_0104, 4'b1111, 32'h0, 1'b0);
    push_done(32'h0000_0005, 1'b0, 2);
    bus_op(1, 0, 0, 0, 0, 1, 32'h0000_0104, 32'h0, 32'h0000_0005, 1, 0, 0);
    @(posedge clk); #1; llsc_clear = 1'b1;
    @(posedge clk); #1; llsc_clear = 1'b0;
    push_imm(1'b0, 1'b0, 1'b1);
    imm_op(0, 1, 0, 1, 1, 32'h0000_0104);

    // Timeout: 1 IDLE cycle + 256 WAIT cycles of stall
    push_req(32'h0000_0040, 4'b1111, 32'h0, 1'b0);
    push_done(32'h0, 1'b1, 257);
    bus_op(1, 0, 0, 0, 0, 0, 32'h0000_0040, 32'h0, 32'h0, 0, 0, 0);

    // Error and ready together: error wins, read data held
    push_req(32'h0000_0000, 4'b0001, 32'h0, 1'b0);
    push_done(32'h0, 1'b1, 2);
    bus_op(1, 0, 1, 0, 0, 0, 32'h0000_0003, 32'h0, 32'h0000_00AB, 1, 1, 0);

    // Flush during WAIT then ready: discarded, no bus error
    push_req(32'h0000_0080, 4'b1111, 32'h0, 1'b0);
    push_done(32'h0, 1'b0, 3);
    bus_op(1, 0, 0, 0, 0, 0, 32'h0000_0080, 32'h0, 32'h0000_DEAD, 2, 0, 1);

    // Reset during WAIT: outputs drop without a clock edge
    @(posedge clk); #1;
    drive(1, 0, 0, 0, 0, 0, 1'b1, 32'h0000_0090, 32'h0, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midrst_enable", 32'(dport_enable), 32'd0);
    chk("midrst_stall", 32'(mem_stall_req), 32'd0);
    idle_inputs();
    @(posedge clk); #1;
    rst = 1'b1;

    // Recovery after reset
    push_req(32'h0000_0094, 4'b1111, 32'h0, 1'b0);
    push_done(32'h0102_0304, 1'b0, 2);
    bus_op(1, 0, 0, 0, 0, 0, 32'h0000_0094, 32'h0, 32'h0102_0304, 1, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
